shift_reg_universal: RTL and testbench

Parametrised universal register built on the team's edge-triggered flip-flop behaviour: a WIDTH-bit register with parallel load, clear, and single-step left/right shift, rotate and arithmetic shift. A multi-step command engine applies a shift or rotate a programmed number of times, one position per clock, with busy/done status. It is the general-purpose register/shifter for lab datapaths (serial links, LED patterns, multiply/divide helpers).

---
 rtl/shift_reg_universal.sv | 133 +++++++++++++
 tb/tb_shift_reg_universal.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_universal.sv
// shift_reg_universal
//   WIDTH-bit universal register. It supports hold, parallel load, left/right
//   shift, rotate, arithmetic shift right and clear. Each operation can run as
//   a single step (en), or as a multi-step command (start/amt) that the
//   command engine applies one position per clock, reporting busy/done.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset (q=RST_VAL, engine idle)
//   en      single-step enable; mode is applied once at the edge
//   start   multi-step request; honoured for shl/shr/rotl/rotr/asr
//   mode    operation select:
//             000 hold, 001 load, 010 shl, 011 shr,
//             100 rotl, 101 rotr, 110 asr, 111 clear
//   amt     step count for a multi-step command
//   d       parallel load data
//   sin_l   serial bit entering the MSB on shr
//   sin_r   serial bit entering the LSB on shl
//   q       register contents
//   sout_l  q[WIDTH-1]
//   sout_r  q[0]
//   busy    multi-step command in progress
//   done    one-cycle pulse after the last step (also after an amt=0 request)
module shift_reg_universal #(
  parameter int unsigned          WIDTH   = 8,
  parameter int unsigned          AW      = 4,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             multi_ok;

  function automatic logic [WIDTH-1:0] step_fn(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    case (m)
      3'b000:  r = v;
      3'b001:  r = ld;
      3'b010:  r = {v[WIDTH-2:0], sr};
      3'b011:  r = {sl, v[WIDTH-1:1]};
      3'b100:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      3'b101:  r = {v[0], v[WIDTH-1:1]};
      3'b110:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Only the shift/rotate family may run as a multi-step command.
  assign multi_ok = (mode >= 3'b010) && (mode <= 3'b110);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && multi_ok) begin
          if (amt != '0) begin
            op_d    = mode;
            cnt_d   = amt;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end else if (en) begin
          q_d = step_fn(mode, q_q, d, sin_l, sin_r);
        end
      end
      RUN: begin
        // Serial inputs are sampled live at every step; mode/d/en are ignored.
        q_d   = step_fn(op_q, q_q, d, sin_l, sin_r);
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= RST_VAL;
      op_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = (state_q == RUN);
  assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
module tb_shift_reg_universal;

  localparam logic [7:0] RV = 8'h3C;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, start, sin_l, sin_r;
  logic [2:0] mode;
  logic [3:0] amt;
  logic [7:0] d;
  logic [7:0] q;
  logic       sout_l, sout_r, busy, done;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // reference model state
  logic [7:0] m_q;
  int         m_left;
  int         m_op;
  bit         m_done;

  shift_reg_universal #(.WIDTH(8), .AW(4), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .amt(amt),
    .d(d), .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l),
    .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit e, input bit s, input logic [2:0] m,
                       input logic [3:0] a, input logic [7:0] dd,
                       input bit sl, input bit sr);
    en = e; start = s; mode = m; amt = a; d = dd; sin_l = sl; sin_r = sr;
  endtask

  // Reset asserted between edges; outputs must respond immediately.
  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check_eq({tag, "_q"}, q, RV);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    #1 rst = 1'b0;
    m_q = RV; m_left = 0; m_done = 0;
  endtask

  function automatic logic [7:0] m_step(int m, logic [7:0] v, logic [7:0] ld, bit sl, bit sr);
    case (m)
      0: return v;
      1: return ld;
      2: return 8'((v << 1) | 8'(sr));
      3: return 8'((v >> 1) | {sl, 7'b0});
      4: return 8'((v << 1) | (v >> 7));
      5: return 8'((v >> 1) | (v << 7));
      6: return 8'($signed(v) >>> 1);
      default: return 8'h00;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit nd = 0;
    if (m_left > 0) begin
      m_q = m_step(m_op, m_q, d, sin_l, sin_r);
      m_left--;
      if (m_left == 0) nd = 1;
    end else if (start && mode >= 2 && mode <= 6) begin
      if (amt == 0) nd = 1;
      else begin m_op = int'(mode); m_left = int'(amt); end
    end else if (en) begin
      m_q = m_step(int'(mode), m_q, d, sin_l, sin_r);
    end
    m_done = nd;
  endtask

  logic [7:0] asr_exp [10] = '{8'hC8, 8'hE4, 8'hF2, 8'hF9, 8'hFC, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    rst = 1'b1;
    drive(0, 0, 3'b000, 4'd0, 8'h00, 0, 0);
    #12 rst = 1'b0;
    check_eq("por_q", q, RV);
    check_eq("por_busy", busy, 0);
    check_eq("por_done", done, 0);

    // single steps
    drive(1, 0, 3'b001, 4'd0, 8'hA5, 0, 0); tick(); check_eq("load", q, 8'hA5);
    check_eq("sout_l", sout_l, 1); check_eq("sout_r", sout_r, 1);
    drive(1, 0, 3'b100, 4'd0, 8'h00, 0, 0); tick(); check_eq("rotl", q, 8'h4B);
    drive(1, 0, 3'b011, 4'd0, 8'h00, 1, 0); tick(); check_eq("shr", q, 8'hA5);
    drive(0, 0, 3'b111, 4'd0, 8'h00, 0, 0); tick(); check_eq("en0_hold", q, 8'hA5);
    drive(1, 0, 3'b111, 4'd0, 8'h00, 0, 0); tick(); check_eq("clear", q, 8'h00);

    // mid-cycle reset after a load
    drive(1, 0, 3'b001, 4'd0, 8'h5A, 0, 0); tick();
    drive(0, 0, 3'b000, 4'd0, 8'h00, 0, 0);
    mid_reset("rst1");

    // multi-step rotr x3
    drive(1, 0, 3'b001, 4'd0, 8'h81, 0, 0); tick();
    drive(0, 1, 3'b101, 4'd3, 8'h00, 0, 0); tick();
    check_eq("rotr_start_q", q, 8'h81); check_eq("rotr_start_busy", busy, 1);
    drive(0, 0, 3'b000, 4'd0, 8'h00, 0, 0);
    tick(); check_eq("rotr_1", q, 8'hC0); check_eq("rotr_b1", busy, 1);
    tick(); check_eq("rotr_2", q, 8'h60); check_eq("rotr_b2", busy, 1);
    tick(); check_eq("rotr_3", q, 8'h30); check_eq("rotr_b3", busy, 0);
    check_eq("rotr_done", done, 1);
    tick(); check_eq("rotr_done_end", done, 0);

    // multi-step asr x10
    drive(1, 0, 3'b001, 4'd0, 8'h90, 0, 0); tick();
    drive(0, 1, 3'b110, 4'd10, 8'h00, 0, 0); tick();
    drive(0, 0, 3'b000, 4'd0, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check_eq("asr_busy", busy, 1);
      tick();
      check_eq($sformatf("asr_%0d", i), q, asr_exp[i]);
    end
    check_eq("asr_busy_end", busy, 0); check_eq("asr_done", done, 1);

    // amt=0 request
    drive(0, 1, 3'b100, 4'd0, 8'h00, 0, 0); tick();
    check_eq("amt0_busy", busy, 0); check_eq("amt0_q", q, 8'hFF); check_eq("amt0_done", done, 1);
    drive(0, 0, 3'b000, 4'd0, 8'h00, 0, 0); tick();
    check_eq("amt0_done_end", done, 0);

    // load attempts during RUN are ignored
    drive(1, 0, 3'b001, 4'd0, 8'h0F, 0, 0); tick();
    drive(0, 1, 3'b010, 4'd2, 8'h00, 0, 0); tick();
    drive(1, 0, 3'b001, 4'd0, 8'hFF, 0, 0);
    tick(); check_eq("run_ign_1", q, 8'h1E);
    tick(); check_eq("run_ign_2", q, 8'h3C); check_eq("run_ign_done", done, 1);

    // reset at step 2 of a 5-step shl
    drive(1, 0, 3'b001, 4'd0, 8'h01, 0, 0); tick();
    drive(0, 1, 3'b010, 4'd5, 8'h00, 0, 0); tick();
    drive(0, 0, 3'b000, 4'd0, 8'h00, 0, 0);
    tick(); check_eq("abort_1", q, 8'h02);
    tick(); check_eq("abort_2", q, 8'h04);
    mid_reset("abort_rst");
    drive(1, 0, 3'b001, 4'd0, 8'h77, 0, 0); tick();
    check_eq("abort_load", q, 8'h77); check_eq("abort_nodone", done, 0);
    check_eq("abort_busy", busy, 0);

    // randomized traffic against the model
    drive(0, 0, 3'b000, 4'd0, 8'h00, 0, 0);
    mid_reset("rnd_init");
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 79) == 0) begin
        mid_reset("rnd_rst");
      end
      drive(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            8'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      tick();
      model_edge();
      check_eq("rnd_q", q, m_q);
      check_eq("rnd_busy", busy, (m_left > 0));
      check_eq("rnd_done", done, m_done);
      check_eq("rnd_soutl", sout_l, m_q[7]);
      check_eq("rnd_soutr", sout_r, m_q[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
